rca_16bit: RTL and testbench

RCA_16BIT -- requirements
Module: rca_16bit

---
 rtl/rca_pkg.sv | 6 +
 rtl/full_adder.sv | 13 +
 rtl/rca_16bit.sv | 50 +++++
 tb/tb_rca_16bit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared constants for the ripple-carry adder slice.
package rca_pkg;

   localparam int unsigned RCA_WIDTH = 16;

endpackage : rca_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational, chained by rca_16bit.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/rca_16bit.sv
// Ripple-carry adder built from full_adder cells, with registered sum and carry out.
module rca_16bit
   import rca_pkg::*;
#(
   parameter int unsigned WIDTH = RCA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   assign carry[0] = cin;

   // Each cell takes its carry from the cell below; no lookahead.
   for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
      full_adder u_fa (
         .a    (in1[gi]),
         .b    (in2[gi]),
         .cin  (carry[gi]),
         .s    (sum_d[gi]),
         .cout (carry[gi+1])
      );
   end

   assign cout_d = carry[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : rca_16bit

// File: tb/tb_rca_16bit.sv
// Scoreboard bench for rca_16bit: driver queues expected {cout,sum}, monitor checks each edge.
module tb_rca_16bit;

   logic        clk;
   logic        rst;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        cin;
   logic [15:0] sum;
   logic        cout;

   logic [16:0] exp_q[$];
   int          n_chk;
   int          n_bad;

   rca_16bit #(.WIDTH(16)) dut (
      .clk  (clk),
      .rst  (rst),
      .in1  (in1),
      .in2  (in2),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
      n_chk++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got cout=%0d sum=%0d, want cout=%0d sum=%0d",
                  name, act[16], act[15:0], req[16], req[15:0]);
      end
   endtask

   // Inputs change on the falling edge; the expected result lands on the next rising edge.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [16:0] e);
      @(negedge clk);
      in1 = a;
      in2 = b;
      cin = c;
      exp_q.push_back(e);
   endtask

   // Monitor: each rising edge out of reset presents one result.
   always @(posedge clk) begin
      #1;
      if (!rst && exp_q.size() > 0) begin
         logic [16:0] e;
         e = exp_q.pop_front();
         check("scoreboard", {cout, sum}, e);
      end
   end

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      n_chk = 0;
      n_bad = 0;
      rst   = 1'b1;
      in1   = 16'd4036;
      in2   = 16'd2917;
      cin   = 1'b0;

      // Held in reset across edges: output stays zero.
      repeat (2) @(posedge clk);
      #2;
      check("reset_hold", {cout, sum}, 17'd0);

      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back({1'b0, 16'd6953});

      issue(16'd51304, 16'd27042, 1'b1, {1'b1, 16'd12811});
      @(posedge clk);
      #3;
      // Inputs moved between edges must not disturb the registered result.
      in1 = 16'd0;
      in2 = 16'd0;
      cin = 1'b0;
      #1;
      check("hold_between_edges", {cout, sum}, {1'b1, 16'd12811});

      issue(16'd32305, 16'd49324, 1'b0, {1'b1, 16'd16093});
      issue(16'd65535, 16'd65535, 1'b1, {1'b1, 16'd65535});
      issue(16'd0,     16'd0,     1'b0, {1'b0, 16'd0});
      issue(16'd0,     16'd0,     1'b1, {1'b0, 16'd1});
      issue(16'd32768, 16'd32768, 1'b0, {1'b1, 16'd0});
      issue(16'd65535, 16'd0,     1'b1, {1'b1, 16'd0});
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_reset_mid_cycle", {cout, sum}, 17'd0);

      // Reset discards pending work; first edge after release takes current inputs.
      @(negedge clk);
      in1 = 16'd1000;
      in2 = 16'd2345;
      cin = 1'b1;
      @(posedge clk);
      #1;
      check("reset_blocks_edge", {cout, sum}, 17'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back({1'b0, 16'd3346});

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         issue(ra, rb, rc, 17'({1'b0, ra}) + 17'({1'b0, rb}) + 17'(rc));
      end

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
      #2;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule : tb_rca_16bit
